// File: rtl/autoplay_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : autoplay_ctrl
// Brief    : Debounced push-button transport (stop/play/pause), song select
//            and beat/note position tracking for the autoplay datapath.
//            Build macro AUTOPLAY_LOOP_EN: song end advances to the next song
//            and keeps playing instead of returning to stop.
// Revision : 1.0 - initial release
// ============================================================================
module autoplay_ctrl #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int BEAT_CYCLES     = 25000000,
  parameter int SONG_LEN        = 32,
  parameter int NUM_SONGS       = 3,
  parameter int IDX_W           = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_play,
  input  logic             btn_stop,
  input  logic             btn_next,
  input  logic             btn_prev,
  output logic [1:0]       state,
  output logic [1:0]       music,
  output logic [IDX_W-1:0] note_idx,
  output logic             beat,
  output logic             song_done
);

  localparam int c_num_btn  = 4;
  localparam int c_btn_stop = 0;
  localparam int c_btn_play = 1;
  localparam int c_btn_next = 2;
  localparam int c_btn_prev = 3;
  localparam int c_db_w     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_bc_w     = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

  localparam logic [c_db_w-1:0] c_db_last   = c_db_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_bc_w-1:0] c_beat_last = c_bc_w'(BEAT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  c_last_note = IDX_W'(SONG_LEN - 1);
  localparam logic [1:0]        c_last_song = 2'(NUM_SONGS - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_PLAY  = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  // ------------------------------------------------------------------------
  // Button conditioning: 2-flop sync, debounce, rising-edge press
  // ------------------------------------------------------------------------
  logic [c_num_btn-1:0] w_btn_raw;
  logic [c_num_btn-1:0] sync1_q, sync1_d;
  logic [c_num_btn-1:0] sync2_q, sync2_d;
  logic [c_num_btn-1:0] deb_q, deb_d;
  logic [c_num_btn-1:0] press_q, press_d;
  logic [c_db_w-1:0]    db_cnt_q [c_num_btn];
  logic [c_db_w-1:0]    db_cnt_d [c_num_btn];

  assign w_btn_raw = {btn_prev, btn_next, btn_play, btn_stop};

  always_comb begin
    sync1_d = w_btn_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    press_d = '0;
    for (int i = 0; i < c_num_btn; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == c_db_last) begin
          deb_d[i]   = sync2_q[i];
          // only a 0->1 change of the debounced level counts as a press
          press_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + c_db_w'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < c_num_btn; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int i = 0; i < c_num_btn; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // ------------------------------------------------------------------------
  // Transport state machine, song select and beat timing
  // ------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [1:0]        music_q, music_d;
  logic [IDX_W-1:0]  note_idx_q, note_idx_d;
  logic [c_bc_w-1:0] beat_cnt_q, beat_cnt_d;
  logic              beat_q, beat_d;
  logic              song_done_q, song_done_d;

  logic       w_stop, w_play, w_next, w_prev;
  logic       w_beat_term, w_last_note;
  logic [1:0] w_music_inc, w_music_dec;

  assign w_stop      = press_q[c_btn_stop];
  assign w_play      = press_q[c_btn_play];
  assign w_next      = press_q[c_btn_next] & ~press_q[c_btn_prev];
  assign w_prev      = press_q[c_btn_prev] & ~press_q[c_btn_next];
  assign w_beat_term = (beat_cnt_q == c_beat_last);
  assign w_last_note = (note_idx_q == c_last_note);
  assign w_music_inc = (music_q == c_last_song) ? 2'd0 : music_q + 2'd1;
  assign w_music_dec = (music_q == 2'd0) ? c_last_song : music_q - 2'd1;

  always_comb begin
    state_d     = state_q;
    music_d     = music_q;
    note_idx_d  = note_idx_q;
    beat_cnt_d  = beat_cnt_q;
    beat_d      = 1'b0;
    song_done_d = 1'b0;
    case (state_q)
      ST_STOP: begin
        note_idx_d = '0;
        beat_cnt_d = '0;
        if (!w_stop) begin
          if (w_play) begin
            state_d = ST_PLAY;
          end else if (w_next) begin
            music_d = w_music_inc;
          end else if (w_prev) begin
            music_d = w_music_dec;
          end
        end
      end
      ST_PLAY: begin
        if (w_stop) begin
          state_d    = ST_STOP;
          note_idx_d = '0;
          beat_cnt_d = '0;
        end else if (w_play) begin
          // pausing on a terminal-count cycle defers that advance to resume
          state_d = ST_PAUSE;
        end else if (w_beat_term) begin
          beat_cnt_d = '0;
          beat_d     = 1'b1;
          if (w_last_note) begin
            note_idx_d  = '0;
            song_done_d = 1'b1;
`ifdef AUTOPLAY_LOOP_EN
            music_d     = w_music_inc;
`else
            state_d     = ST_STOP;
`endif
          end else begin
            note_idx_d = note_idx_q + IDX_W'(1);
          end
        end else begin
          beat_cnt_d = beat_cnt_q + c_bc_w'(1);
        end
      end
      ST_PAUSE: begin
        if (w_stop) begin
          state_d    = ST_STOP;
          note_idx_d = '0;
          beat_cnt_d = '0;
        end else if (w_play) begin
          state_d = ST_PLAY;
        end
      end
      default: begin
        state_d    = ST_STOP;
        note_idx_d = '0;
        beat_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_STOP;
      music_q     <= '0;
      note_idx_q  <= '0;
      beat_cnt_q  <= '0;
      beat_q      <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      music_q     <= music_d;
      note_idx_q  <= note_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      beat_q      <= beat_d;
      song_done_q <= song_done_d;
    end
  end

  assign state     = state_q;
  assign music     = music_q;
  assign note_idx  = note_idx_q;
  assign beat      = beat_q;
  assign song_done = song_done_q;

endmodule
`default_nettype wire

// File: doc/autoplay_ctrl.md
Name: autoplay_ctrl

Overview:
Autoplay transport controller: turns raw push-button inputs into the player state (stop/play/pause) and the song selection, and tracks playback position.
- Drives `state[1:0]` and `music[1:0]` to the autoplay LED indicator and to the note/tone generator.
- Also drives the note index, a per-beat strobe and an end-of-song strobe.
- Sits between the board buttons and the autoplay datapath.

Parameters:
- DEBOUNCE_CYCLES, 2000000: stable-level cycles required before a button change is accepted (20 ms at 100 MHz).
- BEAT_CYCLES, 25000000: clk cycles per note while playing.
- SONG_LEN, 32: notes per song; `note_idx` runs 0..SONG_LEN-1.
- NUM_SONGS, 3: selectable songs; `music` runs 0..NUM_SONGS-1 (max 4).
- IDX_W, 5: width of `note_idx`; must satisfy 2^IDX_W >= SONG_LEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- btn_play  in  1  raw play/pause toggle button, asynchronous to clk.
- btn_stop  in  1  raw stop button.
- btn_next  in  1  raw next-song button.
- btn_prev  in  1  raw previous-song button.
- state  out  2  00 stop, 01 play, 10 pause; 11 never driven.
- music  out  2  selected song, 00..NUM_SONGS-1.
- note_idx  out  IDX_W  current note position.
- beat  out  1  one-cycle pulse on each note advance.
- song_done  out  1  one-cycle pulse when the last note completes.

Behaviour:
- Reset values: `state`=00, `music`=00, `note_idx`=0, `beat`=0, `song_done`=0, beat counter=0. All synchronizer flops, debounce counters and debounced levels are 0.
- Input conditioning, per button:
  - 2-flop synchronizer, then debounce.
  - The debounce counter clears whenever the synced level equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced level and the counter clears.
  - A rising edge of the debounced level gives a 1-cycle internal press.
  - Press latency from a clean input edge is DEBOUNCE_CYCLES+3 cycles. Releases generate nothing.
  - A button held through reset yields one press after the debounce time.
- Press priority within one cycle: stop > play > next/prev. If next and prev are pressed together, both are ignored.
- State machine:
  - STOP: play press -> PLAY, with `note_idx`=0 and beat counter=0.
  - PLAY: stop -> STOP; play -> PAUSE; end of song -> STOP.
  - PAUSE: play -> PLAY (resume; `note_idx` and beat counter retained); stop -> STOP.
  - Entering STOP clears `note_idx` and the beat counter on the same edge.
- Song select:
  - next/prev are honoured only in STOP and are ignored in PLAY/PAUSE.
  - next: `music` = (`music`+1) mod NUM_SONGS, so 2->0.
  - prev: `music` = `music`-1, with 0->NUM_SONGS-1.
- Beat counter:
  - Counts 0..BEAT_CYCLES-1 only in PLAY and holds in PAUSE.
  - At terminal count: counter->0, `beat`=1 for that cycle, `note_idx`+1.
  - If `note_idx` is SONG_LEN-1 at terminal count: `note_idx`->0, `song_done`=1 and `beat`=1 for that cycle, state->STOP.
- Simultaneous events:
  - Stop press on a terminal-count cycle: stop wins; `beat` and `song_done` stay 0.
  - Play press on a terminal-count cycle in PLAY: pause wins; no advance, and the counter holds at terminal count. On resume, the advance occurs on the first PLAY cycle.
- All outputs are registered and change only on posedge clk.
- Reset mid-playback returns to reset values on the next edge regardless of state.

Optional Feature:
- Macro AUTOPLAY_LOOP_EN.
- Defined: at song end, `song_done` pulses as normal, but the block remains in PLAY. `music` advances mod NUM_SONGS and `note_idx` goes to 0 (continuous playlist). Stop and pause behave as without the macro.
- Undefined: at song end, the block returns to STOP with `music` unchanged.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, BEAT_CYCLES=3, SONG_LEN=4, NUM_SONGS=3.
1. Reset, then a clean `btn_play` pulse held 10 cycles -> `state` 00->01 exactly 7 cycles after the input edge; `note_idx`=0.
2. In PLAY -> `beat` pulses every 3 cycles; `note_idx` steps 0,1,2,3. On the 4th beat `song_done`=1, `state`=00, `note_idx`=0 (with AUTOPLAY_LOOP_EN: `state` stays 01 and `music` 00->01).
3. Play, wait 1 beat, press play -> `state`=10 and `note_idx` holds at 1 for 20 cycles. Press play again -> `state`=01 and the next beat arrives with the remaining count preserved.
4. In STOP, press next 3 times -> `music` 01,10,00. Press prev once -> 10. Press next while in PLAY -> `music` unchanged.
5. Assert stop and play with coincident debounced edges while in PLAY -> `state`=00. Glitch `btn_stop` for 2 cycles -> no state change.
6. Assert `rst` for 1 cycle mid-PLAY with `music`=10 and `note_idx`=2 -> next edge gives `state`=00, `music`=00, `note_idx`=0, `beat`=0.
